// File: rtl/bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// bus_bridge_pkg
// Shared types and constants for the serial bus bridge.
//   rsp_tx_state_t  : byte-level UART transmitter states
//   RSP_MARKER      : fixed upper six bits of every response status byte
//   RSP_BIT_*       : positions of the flag bits inside the status byte
//   make_status()   : builds a response status byte from its two flags
// ---------------------------------------------------------------------------
package bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rsp_tx_state_t;

  localparam logic [5:0] RSP_MARKER      = 6'b101000;
  localparam int         RSP_BIT_IS_READ = 0;
  localparam int         RSP_BIT_ERR     = 1;

  function automatic logic [7:0] make_status(input logic is_read, input logic err);
    logic [7:0] s;
    s                  = {RSP_MARKER, 2'b00};
    s[RSP_BIT_IS_READ] = is_read;
    s[RSP_BIT_ERR]     = err;
    return s;
  endfunction

endpackage

// File: rtl/bus_bridge_rsp_uart_tx_if.sv
// ---------------------------------------------------------------------------
// bus_bridge_rsp_uart_tx_if
// Response handshake between the bus-B side and the response transmitter.
//   rsp_valid   : response available (master)
//   rsp_ready   : transmitter idle and able to accept (slave)
//   rsp_is_read : 1 = read response, data byte follows (master)
//   rsp_err     : transaction failed (master)
//   rsp_data    : read data, ignored for writes (master)
//
// Handshake: a transfer happens on a rising clk edge where rsp_valid and
// rsp_ready are both high; the payload is captured on that edge and is
// don't-care afterwards. rsp_valid seen while rsp_ready is low is ignored,
// nothing is queued.
// ---------------------------------------------------------------------------
interface bus_bridge_rsp_uart_tx_if;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_is_read;
  logic       rsp_err;
  logic [7:0] rsp_data;

  modport master (
    output rsp_valid, rsp_is_read, rsp_err, rsp_data,
    input  rsp_ready
  );

  modport slave (
    input  rsp_valid, rsp_is_read, rsp_err, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/bus_bridge_uart_byte_tx.sv
// ---------------------------------------------------------------------------
// bus_bridge_uart_byte_tx
// Serialises one byte as start(0), 8 data bits LSB first, stop(1), each bit
// held for CLKS_PER_BIT cycles on a registered line.
//   clk, rst   : clock, synchronous active-high reset
//   byte_valid : byte_data offered
//   byte_ready : able to take a byte (idle, or last cycle of a stop bit)
//   byte_data  : byte to send, captured when byte_valid && byte_ready
//   byte_done  : high during the final cycle of a stop bit
//   tx         : serial line, idle high
//   state_dbg  : current FSM state
// Accepting in the last stop cycle chains the next start bit directly
// behind the stop bit, so multi-byte frames have no idle gap.
// ---------------------------------------------------------------------------
module bus_bridge_uart_byte_tx
  import bus_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [7:0]    byte_data,
  output logic          byte_done,
  output logic          tx,
  output rsp_tx_state_t state_dbg
);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least 2");
  end

  localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rsp_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             last_tick;
  logic             take;

  assign last_tick  = (baud_cnt_q == CNT_LAST);
  assign byte_ready = (state_q == IDLE) || ((state_q == STOP) && last_tick);
  assign byte_done  = (state_q == STOP) && last_tick;
  assign take       = byte_valid && byte_ready;
  assign tx         = tx_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the line value for the next cycle, so every line change
  // coincides with a state/counter change and comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (take) begin
          state_d    = START;
          baud_cnt_d = '0;
          shift_d    = byte_data;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (last_tick) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            // shift_q[0] is always the bit currently on the line
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          baud_cnt_d = '0;
          if (take) begin
            state_d = START;
            shift_d = byte_data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bus_bridge_rsp_uart_tx.sv
// ---------------------------------------------------------------------------
// bus_bridge_rsp_uart_tx
// Sends one transaction result as a UART frame: status byte
// {RSP_MARKER, err, is_read}, followed by the read data byte for reads
// (error or not).
//   clk, rst     : clock, synchronous active-high reset
//   rsp          : response handshake (slave side)
//   uart_tx      : serial line, idle high
//   busy         : frame in progress, always !rsp_ready
//   frame_done   : one-cycle pulse in the cycle after the last stop bit
//   state_dbg    : byte transmitter FSM state
//   byte_sel_dbg : 0 = status byte in flight, 1 = data byte in flight
// ---------------------------------------------------------------------------
module bus_bridge_rsp_uart_tx
  import bus_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  bus_bridge_rsp_uart_tx_if.slave  rsp,
  output logic                     uart_tx,
  output logic                     busy,
  output logic                     frame_done,
  output rsp_tx_state_t            state_dbg,
  output logic                     byte_sel_dbg
);

  logic       busy_q;
  logic       byte_sel_q;
  logic       is_read_q;
  logic [7:0] data_q;
  logic       frame_done_q;

  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_done;
  logic       accept;
  logic       data_pending;

  // The byte transmitter is always idle when busy_q is low.
  assign rsp.rsp_ready = !busy_q && byte_ready;
  assign busy          = !rsp.rsp_ready;
  assign accept        = rsp.rsp_valid && rsp.rsp_ready;
  assign data_pending  = busy_q && is_read_q && !byte_sel_q;

  // Status byte goes straight from the inputs on the accept edge; the data
  // byte is offered for the whole status byte and is taken on its last
  // stop cycle.
  assign byte_valid   = accept || data_pending;
  assign byte_data    = busy_q ? data_q : make_status(rsp.rsp_is_read, rsp.rsp_err);
  assign frame_done   = frame_done_q;
  assign byte_sel_dbg = byte_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 1'b0;
      byte_sel_q   <= 1'b0;
      is_read_q    <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        busy_q     <= 1'b1;
        byte_sel_q <= 1'b0;
        is_read_q  <= rsp.rsp_is_read;
        data_q     <= rsp.rsp_data;
      end else if (byte_done) begin
        if (data_pending) begin
          byte_sel_q <= 1'b1;
        end else begin
          busy_q       <= 1'b0;
          byte_sel_q   <= 1'b0;
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  bus_bridge_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_done  (byte_done),
    .tx         (uart_tx),
    .state_dbg  (state_dbg)
  );

endmodule

// File: tb/tb_bus_bridge_rsp_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_bus_bridge_rsp_uart_tx
// Bench for the response-frame UART transmitter at CLKS_PER_BIT = 4.
// Expected line waveforms are derived from the frame format (start, 8 data
// bits LSB first, stop, bytes back to back) and an independent mid-bit
// sampling UART receiver decodes the line into bytes compared against the
// expected byte queue.
// ---------------------------------------------------------------------------
module tb_bus_bridge_rsp_uart_tx;
  import bus_bridge_pkg::*;

  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_tx;
  logic          busy;
  logic          frame_done;
  logic          byte_sel_dbg;
  rsp_tx_state_t state_dbg;

  bus_bridge_rsp_uart_tx_if rsp_if();

  bus_bridge_rsp_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rsp          (rsp_if),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .frame_done   (frame_done),
    .state_dbg    (state_dbg),
    .byte_sel_dbg (byte_sel_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         total   = 0;
  int         bad     = 0;
  int         pushes  = 0;
  int         rx_count = 0;
  bit         rx_en   = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level k cycles after the accept edge (k starting at 1).
  function automatic logic exp_line(input logic [7:0] b0, input logic [7:0] b1, input int k);
    int         b;
    int         pos;
    logic [7:0] byt;
    b   = (k - 1) / CPB;
    pos = b % 10;
    byt = (b / 10 == 0) ? b0 : b1;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byt[pos-1];
  endfunction

  // ---------------- reference UART receiver ----------------
  initial begin : rx_model
    logic [7:0] b;
    logic       st;
    logic       sp;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        st = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        sp = uart_tx;
        if (rx_en) begin
          check_eq("rx_start_bit", st, 1'b0);
          check_eq("rx_stop_bit", sp, 1'b1);
          check_eq("rx_byte_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check_eq("rx_byte", b, exp_q.pop_front());
          rx_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Checks every cycle of a frame whose accept edge has just passed, then
  // the frame_done cycle; returns at the negedge of the frame_done cycle.
  task automatic watch_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input int nbytes, input bit scramble);
    int len;
    len = nbytes * 10 * CPB;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (scramble) begin
        rsp_if.rsp_data    = 8'($urandom);
        rsp_if.rsp_is_read = 1'($urandom);
        rsp_if.rsp_err     = 1'($urandom);
      end
      check_eq("tx_bit", uart_tx, exp_line(b0, b1, k));
      check_eq("ready_low", rsp_if.rsp_ready, 1'b0);
      check_eq("busy_high", busy, 1'b1);
      check_eq("done_low", frame_done, 1'b0);
    end
    @(negedge clk);
    check_eq("done_pulse", frame_done, 1'b1);
    check_eq("ready_back", rsp_if.rsp_ready, 1'b1);
    check_eq("busy_low", busy, 1'b0);
    check_eq("tx_idle", uart_tx, 1'b1);
  endtask

  // Called at a negedge; waits for ready, sends one response, checks it.
  task automatic send_frame(input logic is_read, input logic err, input logic [7:0] data);
    int         n;
    logic [7:0] st;
    n = 0;
    while (rsp_if.rsp_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", rsp_if.rsp_ready, 1'b1);
    st = {6'b101000, err, is_read};
    rsp_if.rsp_is_read = is_read;
    rsp_if.rsp_err     = err;
    rsp_if.rsp_data    = data;
    rsp_if.rsp_valid   = 1'b1;
    @(posedge clk);
    #1 rsp_if.rsp_valid = 1'b0;
    exp_q.push_back(st);
    pushes++;
    if (is_read) begin
      exp_q.push_back(data);
      pushes++;
    end
    watch_frame(st, data, is_read ? 2 : 1, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst                = 1'b1;
    rsp_if.rsp_valid   = 1'b0;
    rsp_if.rsp_is_read = 1'b0;
    rsp_if.rsp_err     = 1'b0;
    rsp_if.rsp_data    = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // reset state
    check_eq("rst_tx", uart_tx, 1'b1);
    check_eq("rst_ready", rsp_if.rsp_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    check_eq("rst_byte_sel", byte_sel_dbg, 1'b0);
    rx_en = 1'b1;

    // directed frames: write ok, read ok, write err, read err
    send_frame(1'b0, 1'b0, 8'h5A);
    send_frame(1'b1, 1'b0, 8'h3C);
    send_frame(1'b0, 1'b1, 8'h00);
    send_frame(1'b1, 1'b1, 8'hFF);

    // back-to-back: valid held through the first frame, second response
    // (write error) taken in the frame_done cycle
    @(negedge clk);
    rsp_if.rsp_is_read = 1'b0;
    rsp_if.rsp_err     = 1'b0;
    rsp_if.rsp_valid   = 1'b1;
    @(posedge clk);
    #1 rsp_if.rsp_err = 1'b1;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA2);
    pushes += 2;
    watch_frame(8'hA0, 8'h00, 1, 1'b0);
    @(posedge clk);
    #1 rsp_if.rsp_valid = 1'b0;
    watch_frame(8'hA2, 8'h00, 1, 1'b1);

    // reset during data bit 3 of a write frame
    rx_en = 1'b0;
    @(negedge clk);
    rsp_if.rsp_is_read = 1'b0;
    rsp_if.rsp_err     = 1'b0;
    rsp_if.rsp_valid   = 1'b1;
    @(posedge clk);
    #1 rsp_if.rsp_valid = 1'b0;
    repeat (18) @(negedge clk);
    check_eq("abort_bit3", uart_tx, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_tx", uart_tx, 1'b1);
    check_eq("abort_ready", rsp_if.rsp_ready, 1'b1);
    check_eq("abort_done", frame_done, 1'b0);
    check_eq("abort_state", 32'(state_dbg), 32'(IDLE));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("abort_quiet_done", frame_done, 1'b0);
      check_eq("abort_quiet_tx", uart_tx, 1'b1);
    end
    rx_en = 1'b1;
    send_frame(1'b0, 1'b0, 8'($urandom));

    // valid in the same cycle as reset is not accepted
    @(negedge clk);
    rst                = 1'b1;
    rsp_if.rsp_is_read = 1'b1;
    rsp_if.rsp_valid   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_if.rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_valid_ready", rsp_if.rsp_ready, 1'b1);
      check_eq("rst_valid_tx", uart_tx, 1'b1);
    end

    // randomized responses with random idle gaps (0 = back-to-back)
    for (int n = 0; n < 256; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    repeat (10) @(negedge clk);
    check_eq("rx_all_decoded", exp_q.size(), 0);
    check_eq("rx_count", rx_count, pushes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
